// File: rtl/tff_counter_ctrl_pkg.sv
// Shared types and constants for the toggle-bank counter controller.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_counter_ctrl_if.sv
// Control/status bundle of the toggle-bank counter controller.
// TFF_CTRL_GRAY_OUT_EN adds the registered Gray-coded count.
interface tff_counter_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic             stop;
  logic             pause;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic             cfg_we;
  logic             reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;
`ifdef TFF_CTRL_GRAY_OUT_EN
  logic [WIDTH-1:0] count_gray;
`endif

  modport master (
    output start, stop, pause, dir, limit, cfg_we, reload,
`ifdef TFF_CTRL_GRAY_OUT_EN
    input  count_gray,
`endif
    input  count, tc, busy, done
  );

  modport slave (
    input  start, stop, pause, dir, limit, cfg_we, reload,
`ifdef TFF_CTRL_GRAY_OUT_EN
    output count_gray,
`endif
    output count, tc, busy, done
  );
endinterface

// File: rtl/tff_counter_ctrl_bank.sv
// Bank of WIDTH rising-edge T flip-flops; every bit toggles where t is set.
module tff_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb q_d = q_q ^ t;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Up/down modulo counter controller expressed purely as toggles on a T-FF bank.
// Optional TFF_CTRL_GRAY_OUT_EN: registered Gray-coded copy of the count.
//
// state | meaning
// IDLE  | stopped, bank cleared, waiting for start
// RUN   | counting toward the latched terminal value
// PAUSE | count frozen, resumes when pause drops
// DONE  | one-shot finished, count held
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input logic              clk,
  input logic              reset,
  tff_counter_ctrl_if.slave bus
);

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_inc, t_dec;
  logic [WIDTH-1:0] low_mask;

  // Bit i toggles when all lower bits are 1 (increment) or all 0 (decrement).
  always_comb begin
    t_inc    = '0;
    t_dec    = '0;
    low_mask = '0;
    t_inc[0] = 1'b1;
    t_dec[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      low_mask = {WIDTH{1'b1}} >> (WIDTH - i);
      t_inc[i] = ((count & low_mask) == low_mask);
      t_dec[i] = ((count & low_mask) == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    mode_d  = bus.cfg_we ? bus.reload : mode_q;
    tc_d    = 1'b0;
    t       = '0;
    if (bus.stop) begin
      state_d = IDLE;
      t       = count;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = RUN;
            lim_d   = bus.limit;
            dir_d   = bus.dir;
            t       = count ^ ((bus.dir == DIR_DOWN) ? bus.limit : '0);
          end
        end
        RUN: begin
          // Pause outranks the terminal event, so tc is deferred until resume.
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (dir_q == DIR_UP) begin
            if (count != lim_q) begin
              t = t_inc;
            end else begin
              tc_d = 1'b1;
              if (mode_q) t = count;
              else        state_d = DONE;
            end
          end else begin
            if (count != '0) begin
              t = t_dec;
            end else begin
              tc_d = 1'b1;
              if (mode_q) t = count ^ lim_q;
              else        state_d = DONE;
            end
          end
        end
        PAUSE: begin
          if (!bus.pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lim_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= AUTO_RELOAD;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
    end
  end

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .reset (reset),
    .t     (t),
    .q     (count)
  );

`ifdef TFF_CTRL_GRAY_OUT_EN
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] gray_q, gray_d;

  always_comb begin
    count_next = count ^ t;
    gray_d     = count_next ^ (count_next >> 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gray_q <= '0;
    else       gray_q <= gray_d;
  end

  assign bus.count_gray = gray_q;
`endif

  assign bus.count = count;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed bench for tff_counter_ctrl with hand-computed expected sequences.
module tb_tff_counter_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  tff_counter_ctrl_if #(.WIDTH(8)) bus_if ();

  tff_counter_ctrl #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int exp_cnt, input bit exp_tc,
                           input bit exp_busy, input bit exp_done);
    logic [7:0] e8;
    e8 = exp_cnt[7:0];
    chk({tag, "_cnt"},  32'(bus_if.count), 32'(e8));
    chk({tag, "_tc"},   32'(bus_if.tc),    32'(exp_tc));
    chk({tag, "_busy"}, 32'(bus_if.busy),  32'(exp_busy));
    chk({tag, "_done"}, 32'(bus_if.done),  32'(exp_done));
`ifdef TFF_CTRL_GRAY_OUT_EN
    chk({tag, "_gray"}, 32'(bus_if.count_gray), 32'(e8 ^ (e8 >> 1)));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cnt(input logic d, input logic [7:0] lim);
    bus_if.dir   = d;
    bus_if.limit = lim;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic stop_cnt();
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
  endtask

  task automatic set_mode(input logic r);
    bus_if.reload = r;
    bus_if.cfg_we = 1'b1;
    tick();
    bus_if.cfg_we = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus_if.start  = 1'b0;
    bus_if.stop   = 1'b0;
    bus_if.pause  = 1'b0;
    bus_if.dir    = 1'b0;
    bus_if.limit  = '0;
    bus_if.cfg_we = 1'b0;
    bus_if.reload = 1'b0;
    reset = 1'b1;
    tick();
    check_out("rst", 0, 0, 0, 0);
    #2 reset = 1'b0;

    // Up, limit 9, auto-reload: 0..9 repeating, tc in the cycle after 9.
    start_cnt(1'b0, 8'd9);
    check_out("up9_start", 0, 0, 1, 0);
    for (int k = 1; k <= 25; k++) begin
      tick();
      check_out("up9", k % 10, (k % 10) == 0, 1'b1, 1'b0);
    end

    // Asynchronous reset at count 5, checked before the next clock edge.
    #2 reset = 1'b1;
    #1 check_out("rst_async", 0, 0, 0, 0);
    #1 reset = 1'b0;

    // Down, limit 3, one-shot.
    set_mode(1'b0);
    start_cnt(1'b1, 8'd3);
    check_out("dn3_start", 3, 0, 1, 0);
    tick(); check_out("dn3_a", 2, 0, 1, 0);
    tick(); check_out("dn3_b", 1, 0, 1, 0);
    tick(); check_out("dn3_c", 0, 0, 1, 0);
    tick(); check_out("dn3_done", 0, 1, 0, 1);
    tick(); check_out("dn3_hold", 0, 0, 0, 1);
    tick(); check_out("dn3_hold2", 0, 0, 0, 1);
    start_cnt(1'b1, 8'd3);
    check_out("dn3_restart", 3, 0, 1, 0);
    tick(); check_out("dn3_restart_b", 2, 0, 1, 0);
    stop_cnt();
    check_out("dn3_stop", 0, 0, 0, 0);

    // Limit 0 one-shot: DONE after one cycle.
    start_cnt(1'b0, 8'd0);
    check_out("z1_start", 0, 0, 1, 0);
    tick(); check_out("z1_done", 0, 1, 0, 1);
    stop_cnt();

    // Limit 0 auto-reload: tc every cycle.
    set_mode(1'b1);
    start_cnt(1'b1, 8'd0);
    check_out("z0_start", 0, 0, 1, 0);
    tick(); check_out("z0_a", 0, 1, 1, 0);
    tick(); check_out("z0_b", 0, 1, 1, 0);
    stop_cnt();
    check_out("z0_stop", 0, 0, 0, 0);

    // Down, limit 2, auto-reload reloads to limit.
    start_cnt(1'b1, 8'd2);
    check_out("dn2_start", 2, 0, 1, 0);
    tick(); check_out("dn2_a", 1, 0, 1, 0);
    tick(); check_out("dn2_b", 0, 0, 1, 0);
    tick(); check_out("dn2_rl", 2, 1, 1, 0);
    tick(); check_out("dn2_c", 1, 0, 1, 0);
    stop_cnt();

    // Pause for 4 cycles at count 6.
    start_cnt(1'b0, 8'd9);
    for (int k = 1; k <= 6; k++) tick();
    check_out("pz_at6", 6, 0, 1, 0);
    bus_if.pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_out("pz_hold", 6, 0, 1, 0);
    end
    bus_if.pause = 1'b0;
    tick(); check_out("pz_resume", 6, 0, 1, 0);
    tick(); check_out("pz_7", 7, 0, 1, 0);
    tick(); check_out("pz_8", 8, 0, 1, 0);
    stop_cnt();

    // Stop and start together in RUN: stop wins.
    start_cnt(1'b0, 8'd9);
    for (int k = 1; k <= 3; k++) tick();
    check_out("ss_at3", 3, 0, 1, 0);
    bus_if.stop  = 1'b1;
    bus_if.start = 1'b1;
    tick();
    bus_if.stop  = 1'b0;
    bus_if.start = 1'b0;
    check_out("ss_clr", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("ss_idle", 0, 0, 0, 0);
    end

    // Limit 255 with wrap; pause coincides with count 255.
    start_cnt(1'b0, 8'd255);
    check_out("w_start", 0, 0, 1, 0);
    for (int k = 1; k <= 255; k++) begin
      tick();
      check_out("w_run", k, 0, 1, 0);
    end
    bus_if.pause = 1'b1;
    tick(); check_out("w_pz_a", 255, 0, 1, 0);
    tick(); check_out("w_pz_b", 255, 0, 1, 0);
    bus_if.pause = 1'b0;
    tick(); check_out("w_resume", 255, 0, 1, 0);
    tick(); check_out("w_wrap", 0, 1, 1, 0);
    tick(); check_out("w_after", 1, 0, 1, 0);
    stop_cnt();
    check_out("w_stop", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
